// File: rtl/taxi_dma_ram_rd_stream_if.sv
// Segmented DMA RAM read port: per-segment command and response handshakes.
// Every segment has its own valid/ready pair and moves independently of the others.
interface taxi_dma_ram_if #(
  parameter int SEGS       = 2,
  parameter int SEG_ADDR_W = 8,
  parameter int SEG_DATA_W = 64
) ();
  logic [SEGS-1:0][SEG_ADDR_W-1:0] rd_cmd_addr;
  logic [SEGS-1:0]                 rd_cmd_valid;
  logic [SEGS-1:0]                 rd_cmd_ready;
  logic [SEGS-1:0][SEG_DATA_W-1:0] rd_resp_data;
  logic [SEGS-1:0]                 rd_resp_valid;
  logic [SEGS-1:0]                 rd_resp_ready;

  modport rd_mst (
    output rd_cmd_addr, rd_cmd_valid, rd_resp_ready,
    input  rd_cmd_ready, rd_resp_data, rd_resp_valid
  );

  modport rd_slv (
    input  rd_cmd_addr, rd_cmd_valid, rd_resp_ready,
    output rd_cmd_ready, rd_resp_data, rd_resp_valid
  );
endinterface

// File: rtl/taxi_dma_ram_rd_stream.sv
// Streams len full-width words out of the segmented DMA RAM, starting at a word address.
// SEGS/SEG_ADDR_W/SEG_DATA_W must match the parameters of the interface bound to dma_ram_rd.
module taxi_dma_ram_rd_stream #(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16,
  parameter int SEGS       = 2,
  parameter int SEG_ADDR_W = 8,
  parameter int SEG_DATA_W = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [SEG_ADDR_W-1:0]      cmd_addr,
  input  logic [LEN_W-1:0]           cmd_len,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  taxi_dma_ram_if.rd_mst             dma_ram_rd,
  output logic [SEGS*SEG_DATA_W-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       busy,
  output logic                       done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OUT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                     state_q, state_d;
  logic [SEG_ADDR_W-1:0]      addr_q, addr_d;
  logic [LEN_W-1:0]           len_q, len_d;
  logic [LEN_W-1:0]           issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0]           out_cnt_q, out_cnt_d;
  logic [OUT_W-1:0]           outst_q, outst_d;
  logic [SEGS-1:0]            acc_q, acc_d;
  logic                       done_q, done_d;
  logic [SEGS-1:0][PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]             rd_ptr_q, rd_ptr_d;
  logic [SEG_DATA_W-1:0]      mem_q [SEGS][FIFO_DEPTH];

  logic [SEGS-1:0] fifo_full, fifo_empty, push, acc_now;
  logic            pop, eligible, word_done;

  // All segment FIFOs pop together, so they share one read pointer.
  always_comb begin
    fifo_full  = '0;
    fifo_empty = '0;
    for (int n = 0; n < SEGS; n++) begin
      fifo_empty[n] = (wr_ptr_q[n] == rd_ptr_q);
      fifo_full[n]  = ((wr_ptr_q[n] ^ rd_ptr_q) == {1'b1, {PTR_W{1'b0}}});
    end
  end

  assign push                     = dma_ram_rd.rd_resp_valid & ~fifo_full;
  assign dma_ram_rd.rd_resp_ready = ~fifo_full;

  assign m_axis_tvalid = ~|fifo_empty;
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign m_axis_tlast  = m_axis_tvalid && (out_cnt_q == len_q - LEN_W'(1));

  always_comb begin
    m_axis_tdata = '0;
    for (int n = 0; n < SEGS; n++) begin
      m_axis_tdata[n*SEG_DATA_W +: SEG_DATA_W] = mem_q[n][rd_ptr_q[PTR_W-1:0]];
    end
  end

  // Credit: never have more words in flight than one FIFO can absorb.
  assign eligible  = (state_q == ISSUE) && (outst_q < OUT_W'(FIFO_DEPTH));
  assign dma_ram_rd.rd_cmd_valid = eligible ? ~acc_q : '0;
  assign acc_now   = acc_q | (dma_ram_rd.rd_cmd_valid & dma_ram_rd.rd_cmd_ready);
  assign word_done = eligible && (&acc_now);

  always_comb begin
    for (int n = 0; n < SEGS; n++) begin
      dma_ram_rd.rd_cmd_addr[n] = addr_q;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = pop ? out_cnt_q + LEN_W'(1) : out_cnt_q;
    acc_d       = acc_q;
    done_d      = 1'b0;
    rd_ptr_d    = pop ? rd_ptr_q + (PTR_W+1)'(1) : rd_ptr_q;

    for (int n = 0; n < SEGS; n++) begin
      wr_ptr_d[n] = push[n] ? wr_ptr_q[n] + (PTR_W+1)'(1) : wr_ptr_q[n];
    end

    case ({word_done, pop})
      2'b10:   outst_d = outst_q + OUT_W'(1);
      2'b01:   outst_d = outst_q - OUT_W'(1);
      default: outst_d = outst_q;
    endcase

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len != '0) begin
            addr_d      = cmd_addr;
            len_d       = cmd_len;
            issue_cnt_d = '0;
            out_cnt_d   = '0;
            state_d     = ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        acc_d = acc_now;
        if (word_done) begin
          acc_d       = '0;
          addr_d      = addr_q + SEG_ADDR_W'(1);
          issue_cnt_d = issue_cnt_q + LEN_W'(1);
          if (issue_cnt_q + LEN_W'(1) == len_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_cnt_d == len_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      outst_q     <= '0;
      acc_q       <= '0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      outst_q     <= outst_d;
      acc_q       <= acc_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // A response offered to a full FIFO means the credit accounting is broken.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(|(dma_ram_rd.rd_resp_valid & fifo_full)));
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < SEGS; n++) begin
      if (push[n]) begin
        mem_q[n][wr_ptr_q[n][PTR_W-1:0]] <= dma_ram_rd.rd_resp_data[n];
      end
    end
  end

endmodule

// File: tb/tb_taxi_dma_ram_rd_stream.sv
// Bench for taxi_dma_ram_rd_stream: two-segment RAM model with a two-stage read pipeline
// and a scoreboard of expected output beats filled when each command is driven.
module tb_taxi_dma_ram_rd_stream;

  localparam int SEGS  = 2;
  localparam int AW    = 8;
  localparam int DW    = 64;
  localparam int DEPTH = 8;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [AW-1:0]    cmdAddr = '0;
  logic [LEN_W-1:0] cmdLen = '0;
  logic             cmdValid = 1'b0;
  logic             cmdReady;
  logic [SEGS*DW-1:0] tdata;
  logic             tvalid;
  logic             tready = 1'b1;
  logic             tlast;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  taxi_dma_ram_if #(.SEGS(SEGS), .SEG_ADDR_W(AW), .SEG_DATA_W(DW)) ramIf ();

  taxi_dma_ram_rd_stream #(
    .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W), .SEGS(SEGS), .SEG_ADDR_W(AW), .SEG_DATA_W(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_addr(cmdAddr), .cmd_len(cmdLen), .cmd_valid(cmdValid), .cmd_ready(cmdReady),
    .dma_ram_rd(ramIf),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast),
    .busy(busy), .done(done)
  );

  // RAM word k is {k, ~k}: segment 1 holds k, segment 0 holds ~k.
  function automatic logic [DW-1:0] ramWord(input int seg, input logic [AW-1:0] a);
    logic [DW-1:0] k;
    k = DW'(a);
    return (seg == 1) ? k : ~k;
  endfunction

  bit stallEn = 1'b0;
  bit cmdStall = 1'b0;
  bit respStall = 1'b0;
  logic [SEGS-1:0]         p1v, p2v, adv;
  logic [SEGS-1:0][AW-1:0] p1a, p2a;

  always @(posedge clk) begin
    #2;
    cmdStall  = stallEn && ($urandom_range(0, 1) == 1);
    respStall = stallEn && ($urandom_range(0, 2) == 0);
  end

  always_comb begin
    adv = '0;
    ramIf.rd_cmd_ready  = '0;
    ramIf.rd_resp_valid = '0;
    ramIf.rd_resp_data  = '0;
    for (int n = 0; n < SEGS; n++) begin
      adv[n] = !p2v[n] || (ramIf.rd_resp_ready[n] && !(n == 1 && respStall));
      ramIf.rd_cmd_ready[n]  = adv[n] && !(n == 1 && cmdStall);
      ramIf.rd_resp_valid[n] = p2v[n] && !(n == 1 && respStall);
      ramIf.rd_resp_data[n]  = ramWord(n, p2a[n]);
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      p1v <= '0;
      p2v <= '0;
      p1a <= '0;
      p2a <= '0;
    end else begin
      for (int n = 0; n < SEGS; n++) begin
        if (adv[n]) begin
          p2v[n] <= p1v[n];
          p2a[n] <= p1a[n];
          p1v[n] <= ramIf.rd_cmd_valid[n] && ramIf.rd_cmd_ready[n];
          p1a[n] <= ramIf.rd_cmd_addr[n];
        end
      end
    end
  end

  typedef struct {
    logic [SEGS*DW-1:0] data;
    logic               last;
  } exp_t;

  exp_t expQ[$];
  int vecCount = 0;
  int missCount = 0;
  int beatCount = 0;
  int doneCount = 0;
  int acc0Count = 0;
  bit lastPrev = 1'b0;
  bit holdPrev = 1'b0;
  logic [SEGS*DW-1:0] holdData = '0;

  task automatic checkOutput(input string tag, input logic [SEGS*DW-1:0] got,
                             input logic [SEGS*DW-1:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      lastPrev = 1'b0;
      holdPrev = 1'b0;
    end else begin
      if (lastPrev) checkOutput("done_after_tlast", done, 1);
      if (holdPrev) begin
        checkOutput("hold_tvalid", tvalid, 1);
        checkOutput("hold_tdata", tdata, holdData);
      end
      if (done) doneCount++;
      if (ramIf.rd_cmd_valid[0] && ramIf.rd_cmd_ready[0]) acc0Count++;
      lastPrev = 1'b0;
      holdPrev = tvalid && !tready;
      holdData = tdata;
      if (tvalid && tready) begin
        beatCount++;
        checkOutput("beat_expected", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          checkOutput("tdata", tdata, e.data);
          checkOutput("tlast", tlast, e.last);
        end
        lastPrev = tlast;
      end
    end
  end

  task automatic applyStimulus(input logic [AW-1:0] a, input logic [LEN_W-1:0] n);
    int budget;
    exp_t e;
    logic [AW-1:0] wa;
    budget = 0;
    while (!cmdReady && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    checkOutput("cmd_ready_wait", cmdReady, 1);
    for (int i = 0; i < int'(n); i++) begin
      wa = a + AW'(i);
      e.data = {ramWord(1, wa), ramWord(0, wa)};
      e.last = (i == int'(n) - 1);
      expQ.push_back(e);
    end
    cmdAddr  = a;
    cmdLen   = n;
    cmdValid = 1'b1;
    @(posedge clk); #1;
    cmdValid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int c;
    c = 0;
    while ((busy || expQ.size() != 0) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    checkOutput("idle_in_time", c < budget, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int d0, a0, b0, c;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", cmdReady, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_tvalid", tvalid, 0);
    checkOutput("rst_tlast", tlast, 0);
    checkOutput("rst_rd_cmd_valid", ramIf.rd_cmd_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic len=4 at 0x10");
    d0 = doneCount;
    applyStimulus(8'h10, 4);
    checkOutput("t1_busy_started", busy, 1);
    waitIdle(200);
    checkOutput("t1_done_count", doneCount - d0, 1);
    checkOutput("t1_busy_after", busy, 0);

    $display("[TB] zero length command");
    d0 = doneCount; a0 = acc0Count; b0 = beatCount;
    applyStimulus(8'h33, 0);
    checkOutput("t2_done_next", done, 1);
    checkOutput("t2_cmd_ready", cmdReady, 1);
    checkOutput("t2_busy", busy, 0);
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("t2_no_rd_cmd", ramIf.rd_cmd_valid, 0);
    end
    checkOutput("t2_no_issue", acc0Count - a0, 0);
    checkOutput("t2_no_beats", beatCount - b0, 0);
    checkOutput("t2_done_count", doneCount - d0, 1);
    checkOutput("t2_cmd_ready_after", cmdReady, 1);

    $display("[TB] backpressure len=32");
    tready = 1'b0;
    a0 = acc0Count;
    applyStimulus(8'h40, 32);
    repeat (30) @(posedge clk);
    #1;
    checkOutput("t3_issued_cap", acc0Count - a0, DEPTH);
    checkOutput("t3_rd_cmd_idle", ramIf.rd_cmd_valid, 0);
    checkOutput("t3_tvalid_held", tvalid, 1);
    tready = 1'b1;
    waitIdle(500);

    $display("[TB] segment 1 random stalls len=20");
    stallEn = 1'b1;
    applyStimulus(8'h80, 20);
    waitIdle(3000);
    stallEn = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] address wrap");
    applyStimulus(8'hFE, 4);
    waitIdle(200);

    $display("[TB] reset mid-transfer");
    d0 = doneCount; b0 = beatCount;
    applyStimulus(8'h20, 10);
    c = 0;
    while ((beatCount - b0) < 3 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    checkOutput("t6_reach_beat3", c < 200, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("t6_tvalid_reset", tvalid, 0);
    checkOutput("t6_busy_reset", busy, 0);
    checkOutput("t6_done_reset", done, 0);
    expQ.delete();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t6_no_done", doneCount - d0, 0);
    b0 = beatCount;
    applyStimulus(8'h00, 2);
    waitIdle(200);
    checkOutput("t6_two_beats", beatCount - b0, 2);
    checkOutput("t6_done_once", doneCount - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
